inst_encode_loader: RTL and testbench
=====================================

Name: inst_encode_loader

Overview:
- Sequential RV32I instruction encoder. It is the writer-side counterpart of the instruction decoder.
- Accepts symbolic instruction fields over a valid/ready handshake and packs them into 32-bit machine words. It writes the words sequentially into the instruction ROM write port.
- Supports the same subset the core decodes: ADDI, ADD, SUB, BEQ, BNE, JAL.
- Used for test-program loading and self-check benches.

Parameters:
- ROM_DEPTH, 4096: instruction ROM depth in 32-bit words.
- ADDR_W, 12: ROM word-address width; requires 2^ADDR_W >= ROM_DEPTH.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clear  input  1  synchronous soft restart: pointer to 0, error cleared
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder can accept fields
- in_op  input  3  0=ADDI 1=ADD 2=SUB 3=BEQ 4=BNE 5=JAL 6,7=invalid
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  32  signed immediate / byte offset
- rom_we  output  1  ROM write enable
- rom_waddr  output  ADDR_W  ROM word address
- rom_wdata  output  32  encoded instruction
- word_count  output  ADDR_W+1  number of words written since reset/clear
- full  output  1  ROM_DEPTH words written
- err  output  1  sticky encode error
- err_code  output  2  0 none, 1 bad op, 2 imm out of range, 3 odd offset

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, pointer=0.
  - rom_we=0, rom_waddr=0, rom_wdata=0, word_count=0, full=0, err=0, err_code=0.
  - in_ready=1 in the first cycle after reset.
- clear: same effect as rst, minus nothing. Both take priority over any handshake in the same cycle; the fields are not accepted.
- in_ready = (state==IDLE) && !clear. Transfer occurs when in_valid && in_ready at a clk edge.
- FSM states: IDLE, ENC, WRITE, FULL, ERR.
  - IDLE: on transfer, register the fields and go to ENC.
  - ENC: compute the encoded word and run the checks, registering both.
    - Any check failed: go to ERR, set err=1 and err_code.
    - Otherwise: go to WRITE.
  - WRITE: rom_we=1 for exactly one cycle, with rom_waddr=pointer and rom_wdata=word. At the end of the cycle, pointer++ and word_count++.
    - If the new pointer == ROM_DEPTH: go to FULL.
    - Otherwise: go to IDLE.
  - FULL: full=1, in_ready=0. Exit only via rst/clear.
  - ERR: in_ready=0, err/err_code held. No write occurs for the failing instruction. Exit only via rst/clear.
- Timing: transfer at edge k, rom_we high in the cycle after edge k+1 (write commits at edge k+2). Throughput is 1 instruction per 3 cycles. in_ready returns high the cycle after WRITE.
- Encodings (opcode/funct3/funct7):
  - ADDI: imm[11:0] rs1 000 rd 0010011.
  - ADD: 0000000 rs2 rs1 000 rd 0110011.
  - SUB: 0100000 rs2 rs1 000 rd 0110011.
  - BEQ/BNE: imm[12|10:5] rs2 rs1 000/001 imm[4:1|11] 1100011.
  - JAL: imm[20|10:1|11|19:12] rd 1101111.
- Fields unused by an op are ignored: ADDI ignores rs2; ADD/SUB ignore imm; branches ignore rd; JAL ignores rs1/rs2.
- Checks, in priority order:
  - bad op (6,7) -> code 1.
  - ADDI imm outside [-2048,2047] -> code 2.
  - Branch imm outside [-4096,4094] -> code 2.
  - JAL imm outside [-1048576,1048574] -> code 2.
  - Branch or JAL imm[0]=1 -> code 3.
- Registers x0..x31 are all legal, including rd=x0.
- rom_waddr/rom_wdata hold their last values when rom_we=0.
- word_count saturates at ROM_DEPTH; pointer never wraps.

Test Plan:
- ADDI rd=1 rs1=0 imm=5 -> one rom_we pulse 2 cycles after transfer, addr 0, data 0x00500093, word_count=1.
- ADD rd=3 rs1=1 rs2=2, then SUB same fields -> addr 0: 0x002081B3, addr 1: 0x402081B3; in_ready low for 2 cycles after each transfer.
- BEQ rs1=1 rs2=2 imm=8 -> 0x00208463. BNE rs1=1 rs2=2 imm=-4 -> 0xFE209EE3. JAL rd=1 imm=16 -> 0x010000EF.
- Errors:
  - ADDI imm=2048 -> err=1, err_code=2, no rom_we, in_ready stays 0 through 10 further cycles of in_valid=1.
  - After clear, in_op=6 -> err_code=1.
  - After clear, BEQ imm=3 -> err_code=3.
- ROM_DEPTH=4 override, 4 valid ADDIs -> addrs 0..3, full=1, word_count=4, in_ready=0. A 5th in_valid is not accepted. clear -> full=0, next write at addr 0.
- Reset mid-operation: assert rst in the ENC cycle -> no rom_we; all outputs at reset values the next cycle; a following ADDI writes to addr 0.

Source files
------------

// File: rtl/inst_encode_loader.sv
// inst_encode_loader: packs RV32I fields into machine words and writes them sequentially into the instruction ROM.
module inst_encode_loader #(
  parameter int ROM_DEPTH = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);
  typedef enum logic [2:0] {IDLE, ENC, WRITE, FULL, ERR} state_t;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(ROM_DEPTH);
  state_t state;
  logic [2:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, enc;
  logic signed [31:0] simm;
  logic [1:0] code;
  logic is_br, is_jal, bad_range;
  logic [ADDR_W:0] cnt_next;
  assign in_ready = (state == IDLE) && !clear;
  assign simm = imm;
  assign is_br = (op == 3'd3) || (op == 3'd4);
  assign is_jal = op == 3'd5;
  assign cnt_next = word_count + 1'b1;
  always_comb begin
    bad_range = ((op == 3'd0) && (simm < -2048 || simm > 2047))
             || (is_br && (simm < -4096 || simm > 4094))
             || (is_jal && (simm < -1048576 || simm > 1048574));
    code = (op > 3'd5) ? 2'd1 : bad_range ? 2'd2 : ((is_br || is_jal) && imm[0]) ? 2'd3 : 2'd0;
    enc = (op == 3'd0) ? {imm[11:0], rs1, 3'b000, rd, 7'b0010011}
        : (op == 3'd1) ? {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}
        : (op == 3'd2) ? {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011}
        : is_br ? {imm[12], imm[10:5], rs2, rs1, 2'b00, op == 3'd4, imm[4:1], imm[11], 7'b1100011}
        : {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  end
  // word_count doubles as the write pointer; FULL/ERR are absorbing until rst/clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
      rom_we <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      word_count <= '0;
      full <= 1'b0;
      err <= 1'b0;
      err_code <= 2'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= in_op;
          rd <= in_rd;
          rs1 <= in_rs1;
          rs2 <= in_rs2;
          imm <= in_imm;
          state <= ENC;
        end
        ENC: if (code != 2'd0) begin
          err <= 1'b1;
          err_code <= code;
          state <= ERR;
        end else begin
          rom_we <= 1'b1;
          rom_waddr <= word_count[ADDR_W-1:0];
          rom_wdata <= enc;
          state <= WRITE;
        end
        WRITE: begin
          rom_we <= 1'b0;
          word_count <= cnt_next;
          full <= cnt_next == DEPTH;
          state <= (cnt_next == DEPTH) ? FULL : IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_encode_loader.sv
// tb_inst_encode_loader: directed vectors against a default-depth and a 4-deep encoder.
module tb_inst_encode_loader;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0, valid = 1'b0, clr = 1'b0;
  logic [2:0] in_op = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic v0, c0, v1, c1;
  logic rdy0, we0, full0, err0, rdy1, we1, full1, err1;
  logic [11:0] addr0;
  logic [1:0] addr1, code0, code1;
  logic [31:0] data0, data1;
  logic [12:0] wc0;
  logic [2:0] wc1;
  logic s_rdy, s_we, s_full, s_err;
  logic [11:0] s_addr;
  logic [31:0] s_data;
  logic [12:0] s_wc;
  logic [1:0] s_code;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign v0 = valid && !sel;
  assign v1 = valid && sel;
  assign c0 = clr && !sel;
  assign c1 = clr && sel;
  assign s_rdy = sel ? rdy1 : rdy0;
  assign s_we = sel ? we1 : we0;
  assign s_full = sel ? full1 : full0;
  assign s_err = sel ? err1 : err0;
  assign s_code = sel ? code1 : code0;
  assign s_addr = sel ? 12'(addr1) : addr0;
  assign s_data = sel ? data1 : data0;
  assign s_wc = sel ? 13'(wc1) : wc0;

  inst_encode_loader dut0 (
    .clk(clk), .rst(rst), .clear(c0), .in_valid(v0), .in_ready(rdy0),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .rom_we(we0), .rom_waddr(addr0), .rom_wdata(data0), .word_count(wc0),
    .full(full0), .err(err0), .err_code(code0)
  );

  inst_encode_loader #(.ROM_DEPTH(4), .ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .clear(c1), .in_valid(v1), .in_ready(rdy1),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .rom_we(we1), .rom_waddr(addr1), .rom_wdata(data1), .word_count(wc1),
    .full(full1), .err(err1), .err_code(code1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"}, s_we, 0);
    chk({tag, "_addr"}, s_addr, 0);
    chk({tag, "_data"}, s_data, 0);
    chk({tag, "_wc"}, s_wc, 0);
    chk({tag, "_full"}, s_full, 0);
    chk({tag, "_err"}, s_err, 0);
    chk({tag, "_code"}, s_code, 0);
    chk({tag, "_rdy"}, s_rdy, 1);
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    valid = 1'b1;
  endtask

  task automatic do_instr(input string tag, input logic [2:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [11:0] exp_addr, input logic [31:0] exp_data,
                          input logic [12:0] exp_wc, input logic fin);
    drive(op, rd, rs1, rs2, imm);
    #1 chk({tag, "_rdy_pre"}, s_rdy, 1);
    @(negedge clk);
    valid = 1'b0;
    #1 chk({tag, "_rdy_enc"}, s_rdy, 0);
    chk({tag, "_we_enc"}, s_we, 0);
    @(negedge clk);
    #1 chk({tag, "_we"}, s_we, 1);
    chk({tag, "_addr"}, s_addr, exp_addr);
    chk({tag, "_data"}, s_data, exp_data);
    chk({tag, "_rdy_wr"}, s_rdy, 0);
    @(negedge clk);
    #1 chk({tag, "_we_post"}, s_we, 0);
    chk({tag, "_rdy_post"}, s_rdy, !fin);
    chk({tag, "_wc"}, s_wc, exp_wc);
    chk({tag, "_full"}, s_full, fin);
  endtask

  task automatic do_err(input string tag, input logic [2:0] op, input logic [31:0] imm,
                        input logic [1:0] exp_code);
    drive(op, 5'd1, 5'd1, 5'd2, imm);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #1 chk({tag, "_err"}, s_err, 1);
    chk({tag, "_code"}, s_code, exp_code);
    chk({tag, "_we"}, s_we, 0);
    chk({tag, "_rdy"}, s_rdy, 0);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clr = 1'b1;
    #1 chk({tag, "_rdy_during"}, s_rdy, 0);
    @(negedge clk);
    clr = 1'b0;
    #1 check_reset(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 check_reset("rst");
    rst = 1'b0;
    #1 chk("rst_rdy_after", s_rdy, 1);
    do_instr("addi", 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0, 32'h00500093, 13'd1, 1'b0);
    do_clear("clr1");
    do_instr("add", 3'd1, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0, 32'h002081B3, 13'd1, 1'b0);
    do_instr("sub", 3'd2, 5'd3, 5'd1, 5'd2, 32'd0, 12'd1, 32'h402081B3, 13'd2, 1'b0);
    do_instr("beq", 3'd3, 5'd0, 5'd1, 5'd2, 32'd8, 12'd2, 32'h00208463, 13'd3, 1'b0);
    do_instr("bne", 3'd4, 5'd0, 5'd1, 5'd2, -32'sd4, 12'd3, 32'hFE209EE3, 13'd4, 1'b0);
    do_instr("jal", 3'd5, 5'd1, 5'd7, 5'd9, 32'd16, 12'd4, 32'h010000EF, 13'd5, 1'b0);
    do_instr("addi_min", 3'd0, 5'd0, 5'd2, 5'd0, -32'sd2048, 12'd5, 32'h80010013, 13'd6, 1'b0);
    do_instr("jal_max", 3'd5, 5'd0, 5'd0, 5'd0, 32'd1048574, 12'd6, 32'h7FFFF06F, 13'd7, 1'b0);
    do_instr("beq_min", 3'd3, 5'd0, 5'd0, 5'd0, -32'sd4096, 12'd7, 32'h80000063, 13'd8, 1'b0);
    do_err("e_addi", 3'd0, 32'd2048, 2'd2);
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk("e_hold_rdy", s_rdy, 0);
      chk("e_hold_we", s_we, 0);
      chk("e_hold_code", s_code, 2);
    end
    valid = 1'b0;
    chk("e_hold_wc", s_wc, 8);
    do_clear("clr2");
    do_err("e_op6", 3'd6, 32'd0, 2'd1);
    do_clear("clr3");
    do_err("e_odd", 3'd3, 32'd3, 2'd3);
    do_clear("clr4");
    do_err("e_jal", 3'd5, 32'd1048576, 2'd2);
    do_clear("clr5");
    drive(3'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1 check_reset("midrst");
    rst = 1'b0;
    @(negedge clk);
    #1 chk("midrst_we_after", s_we, 0);
    do_instr("post_rst", 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0, 32'h00500093, 13'd1, 1'b0);
    sel = 1'b1;
    #1 check_reset("d4_init");
    for (int i = 0; i < 4; i++)
      do_instr("d4", 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 12'(i),
               {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011}, 13'(i + 1), i == 3);
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("d4_full_rdy", s_rdy, 0);
      chk("d4_full_we", s_we, 0);
    end
    valid = 1'b0;
    chk("d4_full_wc", s_wc, 4);
    chk("d4_full", s_full, 1);
    do_clear("d4_clr");
    do_instr("d4_again", 3'd0, 5'd9, 5'd0, 5'd0, 32'd5, 12'd0, 32'h00500493, 13'd1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
